// File: rtl/mic_array_pkg.sv
// Shared frame timing constants and state encodings for the mic array front end.
package mic_array_pkg;

    localparam int unsigned CLK_PER_FRAME = 64;
    localparam int unsigned HALF_FRAME    = 32;
    localparam int unsigned SNAP_BIT      = 63;
    localparam int unsigned CNT_W         = $clog2(CLK_PER_FRAME);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } ctrl_state_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } ser_state_e;

endpackage

// File: rtl/mic_frame_sequencer_if.sv
// Valid/ready sample stream from the frame sequencer toward the beamformer.
interface mic_frame_sequencer_if #(
    parameter int unsigned DATAWIDTH = 24,
    parameter int unsigned IDX_W     = 3
) ();

    logic                 out_valid;
    logic                 out_ready;
    logic [DATAWIDTH-1:0] out_data;
    logic [IDX_W-1:0]     out_chan;
    logic                 out_last;
    logic                 out_stale;

    modport master (
        output out_valid,
        output out_data,
        output out_chan,
        output out_last,
        output out_stale,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_chan,
        input  out_last,
        input  out_stale,
        output out_ready
    );

endinterface

// File: rtl/mic_word_serializer.sv
// Holds one frame's snapshot and emits it channel by channel on a valid/ready stream.
module mic_word_serializer
    import mic_array_pkg::*;
#(
    parameter int unsigned NUM_MIC   = 8,
    parameter int unsigned DATAWIDTH = 24,
    parameter int unsigned IDX_W     = 3
) (
    input  logic                           clk_mic,
    input  logic                           rst_mic_n,
    input  logic                           snap,
    input  logic [NUM_MIC*DATAWIDTH-1:0]   snap_data,
    input  logic [NUM_MIC-1:0]             snap_fresh,
    output logic                           busy,
    mic_frame_sequencer_if.master          out_if
);

    ser_state_e                          state_q, state_d;
    logic [IDX_W-1:0]                    idx_q, idx_d;
    logic [NUM_MIC-1:0][DATAWIDTH-1:0]   bank_q, bank_d;
    logic [NUM_MIC-1:0]                  bank_fresh_q, bank_fresh_d;

    logic sending;
    logic last_chan;
    logic cur_fresh;

    assign sending   = (state_q == S_SEND);
    assign last_chan = (idx_q == IDX_W'(NUM_MIC - 1));
    assign cur_fresh = bank_fresh_q[idx_q];
    assign busy      = sending;

    // Stale channels report zero data so downstream never sees last frame's sample.
    assign out_if.out_valid = sending;
    assign out_if.out_chan  = idx_q;
    assign out_if.out_data  = (sending && cur_fresh) ? bank_q[idx_q] : '0;
    assign out_if.out_stale = sending && !cur_fresh;
    assign out_if.out_last  = sending && last_chan;

    // Load the bank only when idle; a snapshot during a transfer is dropped here.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        bank_d       = bank_q;
        bank_fresh_d = bank_fresh_q;
        case (state_q)
            S_IDLE: begin
                if (snap) begin
                    bank_d       = snap_data;
                    bank_fresh_d = snap_fresh;
                    idx_d        = '0;
                    state_d      = S_SEND;
                end
            end
            S_SEND: begin
                if (out_if.out_ready) begin
                    if (last_chan) begin
                        idx_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Serializer state and bank registers.
    always_ff @(posedge clk_mic or negedge rst_mic_n) begin
        if (!rst_mic_n) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            bank_q       <= '0;
            bank_fresh_q <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            bank_q       <= bank_d;
            bank_fresh_q <= bank_fresh_d;
        end
    end

endmodule

// File: rtl/mic_frame_sequencer.sv
// Frame controller: generates WS, captures per-mic results and hands frames to the serializer.
module mic_frame_sequencer
    import mic_array_pkg::*;
#(
    parameter int unsigned NUM_MIC   = 8,
    parameter int unsigned DATAWIDTH = 24,
    parameter int unsigned IDX_W     = 3
) (
    input  logic                         clk_mic,
    input  logic                         rst_mic_n,
    input  logic                         enable,
    output logic                         ws,
    output logic                         frame_start,
    input  logic [NUM_MIC-1:0]           mic_valid,
    input  logic [NUM_MIC*DATAWIDTH-1:0] mic_data,
    mic_frame_sequencer_if.master        out_if,
    output logic [15:0]                  frame_cnt,
    output logic                         overrun,
    input  logic                         clr_overrun
);

    ctrl_state_e                  state_q, state_d;
    logic [CNT_W-1:0]             bit_cnt_q, bit_cnt_d;
    logic                         ws_q, ws_d;
    logic [NUM_MIC*DATAWIDTH-1:0] hold_q, hold_d;
    logic [NUM_MIC-1:0]           fresh_q, fresh_d, cap_fresh;
    logic [15:0]                  frame_cnt_q, frame_cnt_d;
    logic                         overrun_q, overrun_d;

    logic running;
    logic snap;
    logic ser_busy;

    assign running     = (state_q != IDLE);
    assign snap        = running && (bit_cnt_q == CNT_W'(SNAP_BIT));
    assign frame_start = running && (bit_cnt_q == '0);
    assign ws          = ws_q;
    assign frame_cnt   = frame_cnt_q;
    assign overrun     = overrun_q;
    assign ws_d        = running && (bit_cnt_q >= CNT_W'(HALF_FRAME));

    // Frame controller: STOP lets the current frame finish before idling.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q + 1'b1;
        case (state_q)
            IDLE: begin
                bit_cnt_d = '0;
                if (enable) state_d = RUN;
            end
            RUN: begin
                if (!enable) state_d = snap ? IDLE : STOP;
            end
            STOP: begin
                if (enable)    state_d = RUN;
                else if (snap) state_d = IDLE;
            end
            default: begin
                state_d   = IDLE;
                bit_cnt_d = '0;
            end
        endcase
    end

    // Capture: a pulse on the snapshot edge still counts toward the closing frame.
    always_comb begin
        hold_d = hold_q;
        for (int unsigned i = 0; i < NUM_MIC; i++) begin
            if (mic_valid[i]) hold_d[i*DATAWIDTH +: DATAWIDTH] = mic_data[i*DATAWIDTH +: DATAWIDTH];
        end
        cap_fresh = fresh_q | mic_valid;
        fresh_d   = snap ? '0 : cap_fresh;
    end

    // Frame counter and sticky overrun; clear wins over a same-cycle set.
    always_comb begin
        frame_cnt_d = snap ? frame_cnt_q + 16'd1 : frame_cnt_q;
        overrun_d   = overrun_q;
        if (snap && ser_busy) overrun_d = 1'b1;
        if (clr_overrun)      overrun_d = 1'b0;
    end

    // Posedge state for controller, capture and status.
    always_ff @(posedge clk_mic or negedge rst_mic_n) begin
        if (!rst_mic_n) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            hold_q      <= '0;
            fresh_q     <= '0;
            frame_cnt_q <= '0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            hold_q      <= hold_d;
            fresh_q     <= fresh_d;
            frame_cnt_q <= frame_cnt_d;
            overrun_q   <= overrun_d;
        end
    end

    // WS launches on the falling edge so decoders sample it mid-bit.
    always_ff @(negedge clk_mic or negedge rst_mic_n) begin
        if (!rst_mic_n) ws_q <= 1'b0;
        else            ws_q <= ws_d;
    end

    mic_word_serializer #(
        .NUM_MIC   (NUM_MIC),
        .DATAWIDTH (DATAWIDTH),
        .IDX_W     (IDX_W)
    ) u_serializer (
        .clk_mic    (clk_mic),
        .rst_mic_n  (rst_mic_n),
        .snap       (snap),
        .snap_data  (hold_d),
        .snap_fresh (cap_fresh),
        .busy       (ser_busy),
        .out_if     (out_if)
    );

endmodule

// File: tb/tb_mic_frame_sequencer.sv
// Bench for mic_frame_sequencer: randomized mic traffic against a frame-level reference model.
module tb_mic_frame_sequencer;

    localparam int unsigned N  = 8;
    localparam int unsigned DW = 24;
    localparam int unsigned IW = 3;

    typedef struct {
        logic [DW-1:0] data;
        int unsigned   chan;
        bit            last;
        bit            stale;
    } word_t;

    logic          clk_mic     = 1'b0;
    logic          rst_mic_n   = 1'b0;
    logic          enable      = 1'b0;
    logic          clr_overrun = 1'b0;
    logic [N-1:0]  mic_valid   = '0;
    logic [N*DW-1:0] mic_data  = '0;
    logic          ws;
    logic          frame_start;
    logic          overrun;
    logic [15:0]   frame_cnt;

    mic_frame_sequencer_if #(.DATAWIDTH(DW), .IDX_W(IW)) out_if ();

    mic_frame_sequencer #(
        .NUM_MIC   (N),
        .DATAWIDTH (DW),
        .IDX_W     (IW)
    ) dut (
        .clk_mic     (clk_mic),
        .rst_mic_n   (rst_mic_n),
        .enable      (enable),
        .ws          (ws),
        .frame_start (frame_start),
        .mic_valid   (mic_valid),
        .mic_data    (mic_data),
        .out_if      (out_if),
        .frame_cnt   (frame_cnt),
        .overrun     (overrun),
        .clr_overrun (clr_overrun)
    );

    always #5 clk_mic = ~clk_mic;

    int n_pass  = 0;
    int n_total = 0;
    int n_fail  = 0;

    // Reference model: frames are 64 cycles long and run to completion;
    // at each frame end the next frame starts only if enable is high.
    word_t         exp_q[$];
    logic [DW-1:0] m_hold [N];
    bit            m_fresh [N];
    bit            m_active;
    int            m_pos;
    int unsigned   m_frames;
    bit            m_overrun;

    // Stimulus knobs.
    int            mode;        // 0: each mic pulses 0x100+i once per frame, 1: random
    int            ready_mode;  // 0: always ready, 1: never ready, 2: random
    logic [N-1:0]  mute;
    bit            hit63;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        for (int i = 0; i < N; i++) begin
            m_hold[i]  = '0;
            m_fresh[i] = 1'b0;
        end
        m_active  = 1'b0;
        m_pos     = 0;
        m_frames  = 0;
        m_overrun = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, out_if.out_valid, 0);
        check({tag, "_data"}, out_if.out_data, 0);
        check({tag, "_chan"}, out_if.out_chan, 0);
        check({tag, "_last"}, out_if.out_last, 0);
        check({tag, "_stale"}, out_if.out_stale, 0);
        check({tag, "_frame_cnt"}, frame_cnt, 0);
        check({tag, "_overrun"}, overrun, 0);
        check({tag, "_ws"}, ws, 0);
        check({tag, "_frame_start"}, frame_start, 0);
    endtask

    task automatic drive();
        mic_valid = '0;
        for (int i = 0; i < N; i++) begin
            if (mode == 0) begin
                if (m_pos == i * 7 + 1) begin
                    mic_valid[i] = 1'b1;
                    mic_data[i*DW +: DW] = DW'(32'h100 + i);
                end
            end else if ($urandom_range(0, 15) == 0) begin
                mic_valid[i] = 1'b1;
                mic_data[i*DW +: DW] = DW'($urandom);
            end
        end
        if (hit63 && m_pos == 63) begin
            mic_valid[5] = 1'b1;
            mic_data[5*DW +: DW] = 24'h7FFFFF;
        end
        mic_valid = mic_valid & ~mute;
        case (ready_mode)
            0:       out_if.out_ready = 1'b1;
            1:       out_if.out_ready = 1'b0;
            default: out_if.out_ready = ($urandom_range(0, 3) != 0);
        endcase
    endtask

    // One clock: advance the model across the edge, then compare the DUT with it.
    task automatic tick();
        bit    busy;
        bit    snap;
        word_t w;
        busy = (exp_q.size() != 0);
        if (busy && out_if.out_ready) void'(exp_q.pop_front());
        for (int i = 0; i < N; i++) begin
            if (mic_valid[i]) begin
                m_hold[i]  = mic_data[i*DW +: DW];
                m_fresh[i] = 1'b1;
            end
        end
        snap = m_active && (m_pos == 63);
        if (snap) begin
            m_frames = (m_frames + 1) & 32'hFFFF;
            if (busy) begin
                m_overrun = 1'b1;
            end else begin
                for (int i = 0; i < N; i++) begin
                    w.data  = m_fresh[i] ? m_hold[i] : '0;
                    w.chan  = i;
                    w.last  = (i == N - 1);
                    w.stale = !m_fresh[i];
                    exp_q.push_back(w);
                end
            end
            for (int i = 0; i < N; i++) m_fresh[i] = 1'b0;
        end
        if (clr_overrun) m_overrun = 1'b0;
        if (m_active) begin
            if (m_pos == 63) begin
                m_active = enable;
                m_pos    = 0;
            end else begin
                m_pos++;
            end
        end else if (enable) begin
            m_active = 1'b1;
            m_pos    = 0;
        end

        @(posedge clk_mic);
        #1;
        if (exp_q.size() != 0) begin
            check("out_valid", out_if.out_valid, 1);
            check("out_chan", out_if.out_chan, exp_q[0].chan);
            check("out_data", out_if.out_data, exp_q[0].data);
            check("out_last", out_if.out_last, exp_q[0].last);
            check("out_stale", out_if.out_stale, exp_q[0].stale);
        end else begin
            check("out_idle_valid", out_if.out_valid, 0);
            check("out_idle_data", out_if.out_data, 0);
        end
        check("frame_start", frame_start, m_active && (m_pos == 0));
        check("frame_cnt", frame_cnt, m_frames);
        check("overrun", overrun, m_overrun);
        @(negedge clk_mic);
        #1;
        check("ws", ws, m_active && (m_pos >= 32));
    endtask

    task automatic run(input int n);
        repeat (n) begin
            drive();
            tick();
        end
    endtask

    task automatic run_until_pos(input int pos);
        int k;
        k = 0;
        while (!(m_active && m_pos == pos) && k < 200) begin
            drive();
            tick();
            k++;
        end
        if (k >= 200) begin
            n_total++;
            n_fail++;
            $error("FAIL wait_pos: observed no frame position %0d, expected it within 200 cycles", pos);
        end
    endtask

    initial begin
        int k;
        out_if.out_ready = 1'b0;
        mode       = 0;
        ready_mode = 0;
        mute       = '0;
        hit63      = 1'b0;
        model_reset();

        #2;
        check_all_zero("reset");
        @(negedge clk_mic);
        #1;
        rst_mic_n = 1'b1;
        run(3);

        // All mics report each frame.
        enable = 1'b1;
        run(140);

        // Mic 3 silent: its word goes out stale.
        mute = 8'h08;
        run(64);

        // Random captures and random backpressure.
        mode       = 1;
        ready_mode = 2;
        run(192);

        // Stall the stream across a snapshot to force an overrun.
        mode       = 0;
        ready_mode = 0;
        mute       = '0;
        run_until_pos(63);
        run(1);
        run_until_pos(63);
        ready_mode = 1;
        run(71);
        check("overrun_set", overrun, 1);
        check("held_chan", out_if.out_chan, 0);
        check("held_valid", out_if.out_valid, 1);
        clr_overrun = 1'b1;
        run(1);
        clr_overrun = 1'b0;
        check("overrun_clr", overrun, 0);
        ready_mode = 0;
        run(130);

        // A capture on the snapshot edge lands in the closing frame.
        hit63 = 1'b1;
        run(130);
        hit63 = 1'b0;

        // Drop enable mid-frame: the frame completes, then everything goes quiet.
        run_until_pos(10);
        enable = 1'b0;
        run(150);
        check("stopped_ws", ws, 0);
        check("stopped_frame_start", frame_start, 0);
        check("stopped_valid", out_if.out_valid, 0);

        // Reset in the middle of the chan 4 word.
        enable = 1'b1;
        k = 0;
        while (!(exp_q.size() != 0 && exp_q[0].chan == 4) && k < 200) begin
            drive();
            tick();
            k++;
        end
        if (k >= 200) begin
            n_total++;
            n_fail++;
            $error("FAIL wait_chan4: observed no chan 4 word, expected one within 200 cycles");
        end
        rst_mic_n = 1'b0;
        #1;
        check_all_zero("midreset");
        model_reset();
        mic_valid = '0;
        @(negedge clk_mic);
        #1;
        rst_mic_n = 1'b1;
        run(140);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
